// File: rtl/llc_lookup_ctrl_pkg.sv
// Shared LLC types and constants for the lookup controller and its
// round-robin eviction pointer table.
//   - Geometry: 16 ways, 512 sets, 20-bit tags, 3-bit coherence state.
//   - Typedefs for set index, tag, state and way number.
//   - INVALID state encoding (0).
//   - Lookup controller FSM state enum.
package llc_lookup_ctrl_pkg;

  localparam int LLC_WAYS    = 16;
  localparam int LLC_SETS    = 512;
  localparam int LLC_TAG_W   = 20;
  localparam int LLC_STATE_W = 3;
  localparam int LLC_WAY_W   = $clog2(LLC_WAYS);
  localparam int LLC_SET_W   = $clog2(LLC_SETS);

  typedef logic [LLC_SET_W-1:0]   llc_set_t;
  typedef logic [LLC_TAG_W-1:0]   llc_tag_t;
  typedef logic [LLC_STATE_W-1:0] llc_state_t;
  typedef logic [LLC_WAY_W-1:0]   llc_way_t;

  localparam llc_state_t LLC_STATE_INVALID = '0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_LOOK = 3'd3,
    ST_RESP = 3'd4
  } llc_fsm_e;

endpackage

// File: rtl/llc_lookup_ctrl_evict_ptr_table.sv
// Per-set round-robin eviction pointer table.
//   clk, rst   : clock, async active-high reset (clears every pointer to 0)
//   rd_set_i   : set whose pointer is read
//   rd_way_o   : current round-robin start way of rd_set_i (combinational)
//   we_i       : write strobe
//   wr_set_i   : set to update
//   wr_way_i   : way just evicted; the stored pointer becomes wr_way_i + 1,
//                wrapping from the last way back to way 0
module llc_evict_ptr_table
  import llc_lookup_ctrl_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  llc_set_t rd_set_i,
  output llc_way_t rd_way_o,
  input  logic     we_i,
  input  llc_set_t wr_set_i,
  input  llc_way_t wr_way_i
);

  llc_way_t ptr_q [LLC_SETS];
  llc_way_t next_way_d;

  // Way count is a power of two, so the natural overflow of the way width
  // is the wrap to way 0.
  assign next_way_d = llc_way_t'(wr_way_i + llc_way_t'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LLC_SETS; i++) begin
        ptr_q[i] <= '0;
      end
    end else if (we_i) begin
      ptr_q[wr_set_i] <= next_way_d;
    end
  end

  assign rd_way_o = ptr_q[rd_set_i];

endmodule

// File: rtl/llc_lookup_ctrl.sv
// LLC set lookup sequencer.
// Accepts one (set, tag) request at a time, reads the set from the tag/state
// RAM, loads the way-lookup unit's buffers, pulses lookup_en, then returns
// the chosen way and eviction flag. Owns the per-set eviction pointer table.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. req_ready is 1 only in IDLE; once rsp_valid rises, rsp_set,
// rsp_way and rsp_evict hold until the edge where rsp_ready is 1.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   req_valid/req_ready       request handshake; req_set, req_tag payload
//   ram_rd_en, ram_rd_set     tag/state RAM read (data one cycle later)
//   ram_tags, ram_states      RAM read data
//   lookup_en                 one-cycle strobe to the way-lookup unit
//   lk_tag, tags_buf,
//   states_buf, evict_ways_buf  way-lookup unit inputs, stable through LOOK
//   lk_way, lk_evict          way-lookup result (registered in the unit)
//   rsp_valid/rsp_ready       response handshake; rsp_set, rsp_way, rsp_evict
//   dbg_state_o               current FSM state
module llc_lookup_ctrl
  import llc_lookup_ctrl_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  llc_set_t                         req_set,
  input  llc_tag_t                         req_tag,
  output logic                             ram_rd_en,
  output llc_set_t                         ram_rd_set,
  input  logic [LLC_WAYS*LLC_TAG_W-1:0]    ram_tags,
  input  logic [LLC_WAYS*LLC_STATE_W-1:0]  ram_states,
  output logic                             lookup_en,
  output llc_tag_t                         lk_tag,
  output logic [LLC_WAYS*LLC_TAG_W-1:0]    tags_buf,
  output logic [LLC_WAYS*LLC_STATE_W-1:0]  states_buf,
  output llc_way_t                         evict_ways_buf,
  input  llc_way_t                         lk_way,
  input  logic                             lk_evict,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output llc_set_t                         rsp_set,
  output llc_way_t                         rsp_way,
  output logic                             rsp_evict,
  output llc_fsm_e                         dbg_state_o
);

  llc_fsm_e                         state_q, state_d;
  llc_set_t                         set_q;
  llc_tag_t                         tag_q;
  logic [LLC_WAYS*LLC_TAG_W-1:0]    tags_buf_q;
  logic [LLC_WAYS*LLC_STATE_W-1:0]  states_buf_q;
  llc_way_t                         evict_buf_q;
  llc_way_t                         rsp_way_q;
  logic                             rsp_evict_q;
  logic                             rsp_first_q;
  llc_way_t                         ptr_rd_way;
  logic                             ptr_we;

  // Next-state and strobes.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    ram_rd_en = 1'b0;
    lookup_en = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = ST_RD;
      end
      ST_RD: begin
        ram_rd_en = 1'b1;
        state_d   = ST_CAP;
      end
      ST_CAP:  state_d = ST_LOOK;
      ST_LOOK: begin
        lookup_en = 1'b1;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      set_q        <= '0;
      tag_q        <= '0;
      tags_buf_q   <= '0;
      states_buf_q <= '0;
      evict_buf_q  <= '0;
      rsp_way_q    <= '0;
      rsp_evict_q  <= 1'b0;
      rsp_first_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && req_valid) begin
        set_q <= req_set;
        tag_q <= req_tag;
      end
      if (state_q == ST_CAP) begin
        tags_buf_q   <= ram_tags;
        states_buf_q <= ram_states;
        evict_buf_q  <= ptr_rd_way;
      end
      // The way-lookup unit registers its result at the end of LOOK, so the
      // result is only present during the first RESP cycle: pass it straight
      // through then and hold the captured copy for any backpressure cycles.
      rsp_first_q <= (state_q == ST_LOOK);
      if (rsp_first_q) begin
        rsp_way_q   <= lk_way;
        rsp_evict_q <= lk_evict;
      end
    end
  end

  assign rsp_way   = rsp_first_q ? lk_way   : rsp_way_q;
  assign rsp_evict = rsp_first_q ? lk_evict : rsp_evict_q;
  assign rsp_set   = set_q;

  assign ram_rd_set     = set_q;
  assign lk_tag         = tag_q;
  assign tags_buf       = tags_buf_q;
  assign states_buf     = states_buf_q;
  assign evict_ways_buf = evict_buf_q;
  assign dbg_state_o    = state_q;

  // Pointer advances past the evicted way on the response handshake; it lands
  // before any following request reaches its CAP cycle.
  assign ptr_we = (state_q == ST_RESP) && rsp_ready && rsp_evict;

  llc_evict_ptr_table u_ptr_table (
    .clk      (clk),
    .rst      (rst),
    .rd_set_i (set_q),
    .rd_way_o (ptr_rd_way),
    .we_i     (ptr_we),
    .wr_set_i (set_q),
    .wr_way_i (rsp_way)
  );

endmodule
